// File: rtl/bee3_mem_arbiter_if.sv
// Client-side and memory-controller-side signals of the BEE3 memory arbiter.
// The arbiter connects through the slave modport; the environment (clients
// plus AF/WB/RB model) drives the master modport.
interface bee3_mem_arbiter_if;
  // client 0
  logic         c0_req;
  logic         c0_read;
  logic [27:0]  c0_addr;
  logic [127:0] c0_wdata;
  logic         c0_wack;
  logic         c0_gnt;
  logic [127:0] c0_rdata;
  logic         c0_rvalid;
  // client 1
  logic         c1_req;
  logic         c1_read;
  logic [27:0]  c1_addr;
  logic [127:0] c1_wdata;
  logic         c1_wack;
  logic         c1_gnt;
  logic [127:0] c1_rdata;
  logic         c1_rvalid;
  // address FIFO
  logic         writeAF;
  logic         read;
  logic [27:0]  addr;
  logic         AFfull;
  // write buffer
  logic         writeWB;
  logic [31:0]  write_data1;
  logic [31:0]  write_data2;
  logic [31:0]  write_data3;
  logic [31:0]  write_data4;
  logic         WBfull;
  // read buffer
  logic         readRB;
  logic         RBempty;
  logic [31:0]  read_data1;
  logic [31:0]  read_data2;
  logic [31:0]  read_data3;
  logic [31:0]  read_data4;
  // status
  logic         err;

  modport slave (
    input  c0_req, c0_read, c0_addr, c0_wdata,
    output c0_wack, c0_gnt, c0_rdata, c0_rvalid,
    input  c1_req, c1_read, c1_addr, c1_wdata,
    output c1_wack, c1_gnt, c1_rdata, c1_rvalid,
    output writeAF, read, addr,
    input  AFfull,
    output writeWB, write_data1, write_data2, write_data3, write_data4,
    input  WBfull,
    output readRB,
    input  RBempty, read_data1, read_data2, read_data3, read_data4,
    output err
  );

  modport master (
    output c0_req, c0_read, c0_addr, c0_wdata,
    input  c0_wack, c0_gnt, c0_rdata, c0_rvalid,
    output c1_req, c1_read, c1_addr, c1_wdata,
    input  c1_wack, c1_gnt, c1_rdata, c1_rvalid,
    input  writeAF, read, addr,
    output AFfull,
    input  writeWB, write_data1, write_data2, write_data3, write_data4,
    output WBfull,
    input  readRB,
    output RBempty, read_data1, read_data2, read_data3, read_data4,
    input  err
  );
endinterface

// File: rtl/bee3_mem_arbiter.sv
// Two-client round-robin arbiter/sequencer in front of the BEE3 DDR2
// controller. Commands are serialised onto AF/WB (write data beats first,
// then the command); RB beats are steered back to the issuing client via an
// in-order read-tag FIFO.
module bee3_mem_arbiter #(
  parameter int WB_BEATS  = 2,
  parameter int RB_BEATS  = 2,
  parameter int TAG_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  bee3_mem_arbiter_if.slave bus
);

  localparam int WBW = (WB_BEATS > 1) ? $clog2(WB_BEATS) : 1;
  localparam int RBW = (RB_BEATS > 1) ? $clog2(RB_BEATS) : 1;
  localparam int TAW = $clog2(TAG_DEPTH);

  localparam logic [WBW-1:0] WB_LAST = WBW'(WB_BEATS - 1);
  localparam logic [RBW-1:0] RB_LAST = RBW'(RB_BEATS - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WDATA = 2'd1;
  localparam logic [1:0] ST_CMD   = 2'd2;

  // command side state
  logic [1:0]     state_q, state_d;
  logic           win_q, win_d;      // latched winner (0/1)
  logic           read_q, read_d;    // latched command type
  logic [27:0]    addr_q, addr_d;    // latched command address
  logic           last_q, last_d;    // client granted most recently
  logic [WBW-1:0] wbeat_q, wbeat_d;

  // return side state
  logic [RBW-1:0] rbeat_q, rbeat_d;
  logic [TAW:0]   wr_ptr_q, wr_ptr_d;
  logic [TAW:0]   rd_ptr_q, rd_ptr_d;
  logic           rvalid0_q, rvalid0_d;
  logic           rvalid1_q, rvalid1_d;
  logic [127:0]   rdata_q, rdata_d;
  logic           err_q, err_d;

  logic           tag_mem [TAG_DEPTH];

  logic           pick;
  logic           wb_push;
  logic           af_push;
  logic           tag_push;
  logic           tag_pop;
  logic           tag_empty;
  logic           tag_full;
  logic           tag_head;
  logic           rb_pop;
  logic           rb_hit;
  logic [127:0]   wdata_sel;

  // A lone requester wins; on a tie the client not granted last wins.
  assign pick = (bus.c0_req && bus.c1_req) ? ~last_q : bus.c1_req;

  assign tag_empty = (wr_ptr_q == rd_ptr_q);
  assign tag_full  = (wr_ptr_q[TAW] != rd_ptr_q[TAW]) &&
                     (wr_ptr_q[TAW-1:0] == rd_ptr_q[TAW-1:0]);
  assign tag_head  = tag_mem[rd_ptr_q[TAW-1:0]];

  // Pushes depend only on registered state and the full flags, so no
  // client request ever reaches an output combinationally.
  assign wb_push   = (state_q == ST_WDATA) && !bus.WBfull;
  assign af_push   = (state_q == ST_CMD) && !bus.AFfull && (!read_q || !tag_full);
  assign tag_push  = af_push && read_q;

  assign rb_pop    = !bus.RBempty;
  assign rb_hit    = rb_pop && !tag_empty;
  assign tag_pop   = rb_hit && (rbeat_q == RB_LAST);

  assign wdata_sel = win_q ? bus.c1_wdata : bus.c0_wdata;

  // memory controller outputs
  assign bus.writeWB     = wb_push;
  assign bus.write_data1 = wb_push ? wdata_sel[31:0]   : 32'd0;
  assign bus.write_data2 = wb_push ? wdata_sel[63:32]  : 32'd0;
  assign bus.write_data3 = wb_push ? wdata_sel[95:64]  : 32'd0;
  assign bus.write_data4 = wb_push ? wdata_sel[127:96] : 32'd0;
  assign bus.writeAF     = af_push;
  assign bus.read        = af_push && read_q;
  assign bus.addr        = af_push ? addr_q : 28'd0;
  assign bus.readRB      = rb_pop;
  assign bus.err         = err_q;

  // client outputs
  assign bus.c0_wack   = wb_push && !win_q;
  assign bus.c1_wack   = wb_push &&  win_q;
  assign bus.c0_gnt    = af_push && !win_q;
  assign bus.c1_gnt    = af_push &&  win_q;
  assign bus.c0_rvalid = rvalid0_q;
  assign bus.c1_rvalid = rvalid1_q;
  assign bus.c0_rdata  = rdata_q;
  assign bus.c1_rdata  = rdata_q;

  // Command FSM: arbitrate, stream write beats, then push the AF entry.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    read_d  = read_q;
    addr_d  = addr_q;
    last_d  = last_q;
    wbeat_d = wbeat_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.c0_req || bus.c1_req) begin
          win_d   = pick;
          read_d  = pick ? bus.c1_read : bus.c0_read;
          addr_d  = pick ? bus.c1_addr : bus.c0_addr;
          wbeat_d = '0;
          state_d = (pick ? bus.c1_read : bus.c0_read) ? ST_CMD : ST_WDATA;
        end
      end
      ST_WDATA: begin
        if (wb_push) begin
          if (wbeat_q == WB_LAST) begin
            wbeat_d = '0;
            state_d = ST_CMD;
          end else begin
            wbeat_d = wbeat_q + WBW'(1);
          end
        end
      end
      ST_CMD: begin
        if (af_push) begin
          last_d  = win_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Return path: pop RB, steer each beat by the tag FIFO head, flag orphans.
  always_comb begin
    rbeat_d   = rbeat_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rvalid0_d = rb_hit && !tag_head;
    rvalid1_d = rb_hit &&  tag_head;
    rdata_d   = rb_hit ? {bus.read_data4, bus.read_data3, bus.read_data2, bus.read_data1}
                       : rdata_q;
    err_d     = err_q || (rb_pop && tag_empty);
    if (tag_push) wr_ptr_d = wr_ptr_q + (TAW+1)'(1);
    if (rb_hit) begin
      if (tag_pop) begin
        rbeat_d  = '0;
        rd_ptr_d = rd_ptr_q + (TAW+1)'(1);
      end else begin
        rbeat_d  = rbeat_q + RBW'(1);
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      win_q     <= 1'b0;
      read_q    <= 1'b0;
      addr_q    <= '0;
      last_q    <= 1'b1;   // makes client 0 win the first tie
      wbeat_q   <= '0;
      rbeat_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      read_q    <= read_d;
      addr_q    <= addr_d;
      last_q    <= last_d;
      wbeat_q   <= wbeat_d;
      rbeat_q   <= rbeat_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // Tag storage: client id of each outstanding read, in issue order.
  always_ff @(posedge clk) begin
    if (tag_push) tag_mem[wr_ptr_q[TAW-1:0]] <= win_q;
  end

endmodule
